airlock_controller: RTL
=======================

# airlock_controller

Chamber sequencer for the airlock. It takes the 8-bit chamber `pressure` from the pressure unit and drives that unit's `startPressurization` / `startDepressurization` inputs. It interlocks the inner and outer door unlocks against chamber pressure and door-closed sensors, and latches a fault on timeout or door breach.

## Interface
Parameters:
- `HIGH_PRESSURE`, 8'hFF, chamber pressure equal to the inside; matches the pressure unit's reset value.
- `LOW_PRESSURE`, 8'h00, chamber pressure equal to the outside.
- `SETTLE_CYCLES`, 4, hold time at target before a door unlocks; must be ≥1.
- `TIMEOUT_CYCLES`, 4095, maximum cycles allowed in a pump state.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `pressure` in 8: current chamber pressure.
- `cycleToOuter` in 1: request to pump down and open the outer side.
- `cycleToInner` in 1: request to pump up and open the inner side.
- `innerDoorClosed` in 1: inner door sensor; 1 = closed.
- `outerDoorClosed` in 1: outer door sensor; 1 = closed.
- `startPressurization` out 1: to pressure unit; raises pressure.
- `startDepressurization` out 1: to pressure unit; lowers pressure.
- `innerDoorUnlock` out 1: inner door may open.
- `outerDoorUnlock` out 1: outer door may open.
- `busy` out 1: chamber is cycling.
- `fault` out 1: latched fault.

## Operation
- States: INNER_ACCESS, DEPRESS, SETTLE_OUT, OUTER_ACCESS, PRESS, SETTLE_IN, FAULT.
- Reset state: INNER_ACCESS.
- Reset values: `innerDoorUnlock`=1; all other outputs 0; pending flag 0; timer 0.
- INNER_ACCESS:
  - `innerDoorUnlock`=1.
  - `cycleToOuter` sets the pending flag.
  - Pending (or current request) with `innerDoorClosed`=1 → DEPRESS.
  - Pending with door open: wait, flag held.
  - `cycleToInner` is ignored.
- DEPRESS:
  - `startDepressurization` = (`pressure` > `LOW_PRESSURE`); combinational so the pressure unit never decrements past target and wraps to 8'hFF.
  - `pressure` ≤ `LOW_PRESSURE` → SETTLE_OUT.
- SETTLE_OUT: no pump, no unlock; after `SETTLE_CYCLES` cycles → OUTER_ACCESS.
- OUTER_ACCESS:
  - `outerDoorUnlock`=1.
  - Mirror of INNER_ACCESS: `cycleToInner` latches pending; with `outerDoorClosed`=1 → PRESS.
  - `cycleToOuter` is ignored.
- PRESS:
  - `startPressurization` = (`pressure` < `HIGH_PRESSURE`).
  - `pressure` ≥ `HIGH_PRESSURE` → SETTLE_IN.
- SETTLE_IN: `SETTLE_CYCLES` cycles → INNER_ACCESS.
- FAULT:
  - Entered from DEPRESS, SETTLE_*, or PRESS if either door sensor reads 0.
  - Entered from DEPRESS/PRESS if the timer reaches `TIMEOUT_CYCLES` before target.
  - Outputs: all pump and unlock outputs 0, `fault`=1.
  - Exit only by `reset`.
- Pending flag clears on leaving an ACCESS state.
- `busy` = 1 in DEPRESS, SETTLE_OUT, PRESS, SETTLE_IN.
- Never are both pump outputs 1 together; never are both unlocks 1 together.

## Timing
- Unlock, busy, and fault outputs decode from the state register; pump outputs also gate on the live `pressure` compare.
- Request accepted at edge t with door closed: pump output high in cycle t+1.
- Target seen at edge t: pump output drops in the same cycle (combinational). SETTLE state begins at t+1; unlock asserts at t+1+`SETTLE_CYCLES`.
- Timer:
  - Clears on every state entry.
  - Counts each cycle in DEPRESS/PRESS/SETTLE_*.
  - Width $clog2(`TIMEOUT_CYCLES`+1); saturates, never wraps.
- Simultaneous target reached and timeout on the same edge: target wins.
- Simultaneous door breach and any other transition: FAULT wins.
- `reset` mid-cycle returns to INNER_ACCESS next edge; the pressure unit restarts at 8'hFF.

## Structure
- `airlock_pkg`:
  - State encoding localparams (3 bits).
  - Default `HIGH_PRESSURE` / `LOW_PRESSURE`.
- Sub-module `airlock_timer`:
  - Clearable, saturating up-counter.
  - Compare outputs `settleDone` and `timedOut`, shared by the settle and pump states.

## Test plan
- Reset, `pressure`=8'hFF → INNER_ACCESS; `innerDoorUnlock`=1, all else 0.
- `cycleToOuter` with inner door closed; model pressure decrementing every 7 cycles → `startDepressurization` 1 until `pressure`=8'h00, dropping in that same cycle; `outerDoorUnlock`=1 exactly 1+4 cycles later; pressure never reads 8'hFF again.
- `cycleToOuter` pulsed while `innerDoorClosed`=0; close the door 10 cycles later → DEPRESS on the next edge (pending flag held).
- Full round trip back to 8'hFF via `cycleToInner` → INNER_ACCESS; `startPressurization` never overlaps `startDepressurization`.
- Pressure frozen at 8'h80 in DEPRESS → `fault`=1 after 4095 cycles, all drives 0; `reset` → INNER_ACCESS.
- `outerDoorClosed` drops during PRESS → FAULT next edge; requests ignored until `reset`.

Source files
------------

// File: rtl/airlock_pkg.sv
// Shared state encoding and default pressure targets for the airlock sequencer.
package airlock_pkg;

    localparam logic [2:0] ST_INNER_ACCESS = 3'd0;
    localparam logic [2:0] ST_DEPRESS      = 3'd1;
    localparam logic [2:0] ST_SETTLE_OUT   = 3'd2;
    localparam logic [2:0] ST_OUTER_ACCESS = 3'd3;
    localparam logic [2:0] ST_PRESS        = 3'd4;
    localparam logic [2:0] ST_SETTLE_IN    = 3'd5;
    localparam logic [2:0] ST_FAULT        = 3'd6;

    typedef enum logic [2:0] {
        INNER_ACCESS = ST_INNER_ACCESS,
        DEPRESS      = ST_DEPRESS,
        SETTLE_OUT   = ST_SETTLE_OUT,
        OUTER_ACCESS = ST_OUTER_ACCESS,
        PRESS        = ST_PRESS,
        SETTLE_IN    = ST_SETTLE_IN,
        FAULT        = ST_FAULT
    } state_t;

    localparam logic [7:0] DEFAULT_HIGH_PRESSURE = 8'hFF;
    localparam logic [7:0] DEFAULT_LOW_PRESSURE  = 8'h00;

    function automatic logic is_busy(input state_t s);
        return (s == DEPRESS) || (s == SETTLE_OUT) || (s == PRESS) || (s == SETTLE_IN);
    endfunction

endpackage

// File: rtl/airlock_timer.sv
// Clearable saturating cycle counter shared by the pump and settle states.
// clear zeroes the count seen in the same cycle, so a state's first cycle reads 0.
module airlock_timer #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic settleDone,
    output logic timedOut
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT       = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] SETTLE_LAST = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] count;
    logic [W-1:0] current;

    assign current = clear ? '0 : count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (enable && (current != LIMIT)) begin
            count <= current + W'(1);
        end else begin
            count <= current;
        end
    end

    // Settle ends on its last counted cycle so the state lasts exactly SETTLE_CYCLES.
    assign settleDone = (current >= SETTLE_LAST);
    assign timedOut   = (current >= LIMIT);

endmodule

// File: rtl/airlock_controller.sv
// Airlock chamber sequencer: pumps the chamber between inside and outside pressure
// and interlocks the door unlocks; any door breach or pump timeout latches a fault.
module airlock_controller
    import airlock_pkg::*;
#(
    parameter logic [7:0]  HIGH_PRESSURE  = DEFAULT_HIGH_PRESSURE,
    parameter logic [7:0]  LOW_PRESSURE   = DEFAULT_LOW_PRESSURE,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] pressure,
    input  logic       cycleToOuter,
    input  logic       cycleToInner,
    input  logic       innerDoorClosed,
    input  logic       outerDoorClosed,
    output logic       startPressurization,
    output logic       startDepressurization,
    output logic       innerDoorUnlock,
    output logic       outerDoorUnlock,
    output logic       busy,
    output logic       fault
);

    state_t state;
    logic   pending;
    logic   entry;
    logic   settleDone;
    logic   timedOut;
    logic   breach;

    assign breach = !(innerDoorClosed && outerDoorClosed);

    airlock_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clear     (entry),
        .enable    (busy),
        .settleDone(settleDone),
        .timedOut  (timedOut)
    );

    // entry pulses for the first cycle of every new state so the timer restarts at 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= INNER_ACCESS;
            pending <= 1'b0;
            entry   <= 1'b0;
        end else begin
            entry <= 1'b0;
            case (state)
                INNER_ACCESS: begin
                    if ((pending || cycleToOuter) && innerDoorClosed) begin
                        state   <= DEPRESS;
                        pending <= 1'b0;
                        entry   <= 1'b1;
                    end else if (cycleToOuter) begin
                        pending <= 1'b1;
                    end
                end
                DEPRESS: begin
                    if (breach) begin
                        state <= FAULT;
                        entry <= 1'b1;
                    end else if (pressure <= LOW_PRESSURE) begin
                        state <= SETTLE_OUT;
                        entry <= 1'b1;
                    end else if (timedOut) begin
                        state <= FAULT;
                        entry <= 1'b1;
                    end
                end
                SETTLE_OUT: begin
                    if (breach) begin
                        state <= FAULT;
                        entry <= 1'b1;
                    end else if (settleDone) begin
                        state <= OUTER_ACCESS;
                        entry <= 1'b1;
                    end
                end
                OUTER_ACCESS: begin
                    if ((pending || cycleToInner) && outerDoorClosed) begin
                        state   <= PRESS;
                        pending <= 1'b0;
                        entry   <= 1'b1;
                    end else if (cycleToInner) begin
                        pending <= 1'b1;
                    end
                end
                PRESS: begin
                    if (breach) begin
                        state <= FAULT;
                        entry <= 1'b1;
                    end else if (pressure >= HIGH_PRESSURE) begin
                        state <= SETTLE_IN;
                        entry <= 1'b1;
                    end else if (timedOut) begin
                        state <= FAULT;
                        entry <= 1'b1;
                    end
                end
                SETTLE_IN: begin
                    if (breach) begin
                        state <= FAULT;
                        entry <= 1'b1;
                    end else if (settleDone) begin
                        state <= INNER_ACCESS;
                        entry <= 1'b1;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= FAULT;
                    entry <= 1'b1;
                end
            endcase
        end
    end

    assign innerDoorUnlock = (state == INNER_ACCESS);
    assign outerDoorUnlock = (state == OUTER_ACCESS);
    assign busy            = is_busy(state);
    assign fault           = (state == FAULT);

    // Pump drives drop the same cycle the target is seen so the unit never overshoots.
    assign startDepressurization = (state == DEPRESS) && (pressure > LOW_PRESSURE);
    assign startPressurization   = (state == PRESS) && (pressure < HIGH_PRESSURE);

endmodule
